dm_arbiter: RTL
===============

# dm_arbiter

Sequencing and arbitration controller for the single-port synchronous data memory behind the M stage. It shares that memory between two requesters: the pipeline's load/store path, and an external word-wide port used for program loading and debug. It also generates byte enables, load extraction with sign/zero extension, and the pipeline stall. It sits between the M stage and the RAM macro, which has 1-cycle read latency.

## Interface
- ADDR_W, 12: word-address bits driven to RAM; byte address bits [ADDR_W+1:2] are used, higher bits ignored (wrap).
- STARVE, 4: ext wait cycles (1..15) after which ext wins the next arbitration.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  M-stage access request; held stable while cpu_stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_width  in  2  00 word, 01 half, 10 byte (11 treated as word)
- cpu_sign  in  1  1=sign-extend loads, 0=zero-extend
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  extended load data, valid when cpu_done=1 for a load, else 0
- cpu_done  out  1  access completes this cycle
- cpu_exc  out  1  misaligned access, asserted with cpu_done
- cpu_stall  out  1  cpu_req & ~cpu_done
- ext_req  in  1  external word access request, held until ext_done
- ext_we  in  1  1=write, 0=read
- ext_addr  in  32  byte address, bits [1:0] ignored
- ext_wdata  in  32  write word
- ext_rdata  out  32  read word, valid when ext_done=1 for a read, else 0
- ext_done  out  1  external access completes this cycle
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables, bit i = lane i (bits [8i+7:8i])
- ram_addr  out  ADDR_W  word address
- ram_wdata  out  32  lane-positioned write data
- ram_rdata  in  32  RAM output, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, CPU_RD, EXT_RD.
- Arbitration happens only in IDLE.
  - ext wins if ext_req & (wait_cnt==STARVE | ~cpu_req).
  - Otherwise cpu wins if cpu_req.
- Misaligned cpu access: half with addr[0]=1, or word with addr[1:0]!=0.
  - If cpu wins with a misaligned access: cpu_exc=1, cpu_done=1 that cycle, no RAM strobe, stay IDLE.
- Write granted (either port): ram_en=1, ram_we set, done=1 in the same cycle, stay IDLE.
- Read granted: ram_en=1, ram_we=0, go to CPU_RD or EXT_RD. In that state, done=1 with data from ram_rdata, return to IDLE. No new grant is made in CPU_RD or EXT_RD.
- Byte store: ram_we=1<<addr[1:0]; ram_wdata = byte replicated ×4.
- Half store: ram_we = addr[1] ? 1100 : 0011; ram_wdata = half replicated ×2.
- Word store: ram_we=1111. All ext writes use 1111.
- Loads: select the lane by the latched addr[1:0], then extend to 32 bits per the latched cpu_sign.
  - Width, offset and sign are latched at grant.
- wait_cnt: increments each cycle ext_req=1 and ext is not granted; saturates at STARVE; cleared on ext grant or when ext_req=0.

## Timing
- Reset values: state IDLE, wait_cnt 0. All outputs 0, except cpu_stall, which follows cpu_req.
- Store or exception: 1 cycle, combinational done.
- Load: 2 cycles (grant cycle, then done cycle); cpu_stall high in the grant cycle.
- Back-to-back: a request arriving during a CPU_RD or EXT_RD done cycle is first arbitrated in the following IDLE cycle.
- Simultaneous cpu_req and ext_req with wait_cnt<STARVE: cpu wins and ext waits.
- Under continuous cpu traffic, ext is granted within STARVE+2 cycles.
- Reset during CPU_RD or EXT_RD:
  - The pending read is dropped.
  - No done is asserted that cycle or the next.
  - Any write already strobed stands.
- Done outputs last exactly one cycle per access; the requester deasserts or changes its request on the cycle after done.

## Test plan
- Store byte 0xA5 at addr 0x0000_0006 -> same cycle ram_en=1, ram_we=0100, ram_wdata=0xA5A5A5A5, ram_addr=1, cpu_done=1, cpu_stall=0.
- Load half signed at 0x0000_0002 with ram_rdata=0x8001_1234 on the next cycle -> cycle 0: cpu_stall=1, ram_en=1, ram_we=0. Cycle 1: cpu_done=1, cpu_rdata=0xFFFF_8001. Unsigned variant -> 0x0000_8001.
- Word load at 0x0000_0005 -> cpu_exc=1, cpu_done=1 same cycle, ram_en=0, state stays IDLE.
- cpu_req held high with back-to-back stores while ext_req=1 (read, addr 0x10) -> ext granted in cycle STARVE+1 (5 with default), ram_addr=4. ext_done with ram_rdata on the following cycle; wait_cnt then 0.
- cpu_req and ext_req both high from IDLE, wait_cnt=0 -> cpu granted first; ext granted in the first IDLE cycle after cpu's done.
- Assert reset in a CPU_RD cycle -> next cycle cpu_done=0, cpu_rdata=0, state IDLE; a re-issued load completes normally 2 cycles later.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bundle of the M-stage, external-port and RAM-macro signals around dm_arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface dm_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_width;
    logic              cpu_sign;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_exc;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic [31:0]       ext_rdata;
    logic              ext_done;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_exc, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_done,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_exc, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_done,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares a single-port, 1-cycle-latency data RAM between the M-stage load/store
// path and an external word port; builds byte enables, load extension and stall.
module dm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_t;

    localparam logic [3:0] STARVE_C = 4'(STARVE);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [1:0]  rd_off;
    logic [1:0]  rd_width;
    logic        rd_sign;

    logic        cpu_byte, cpu_half, misaligned;
    logic        ext_win, cpu_win;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic        unused_bits;

    assign unused_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.ext_addr[31:ADDR_W+2],
                           bus.ext_addr[1:0]};

    assign cpu_byte   = (bus.cpu_width == 2'b10);
    assign cpu_half   = (bus.cpu_width == 2'b01);
    assign misaligned = (cpu_half & bus.cpu_addr[0]) |
                        (~cpu_half & ~cpu_byte & (|bus.cpu_addr[1:0]));

    // Grants exist only in IDLE and never while reset is held.
    assign ext_win = (state == IDLE) & ~reset & bus.ext_req &
                     ((wait_cnt == STARVE_C) | ~bus.cpu_req);
    assign cpu_win = (state == IDLE) & ~reset & bus.cpu_req & ~ext_win;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        store_be   = 4'b1111;
        store_data = bus.cpu_wdata;
        if (cpu_byte) begin
            store_be   = 4'b0001 << bus.cpu_addr[1:0];
            store_data = {4{bus.cpu_wdata[7:0]}};
        end else if (cpu_half) begin
            store_be   = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{bus.cpu_wdata[15:0]}};
        end
    end

    always_comb begin
        load_byte = bus.ram_rdata[{rd_off, 3'b000} +: 8];
        load_half = rd_off[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        unique case (rd_width)
            2'b10:   load_ext = {{24{rd_sign & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{16{rd_sign & load_half[15]}}, load_half};
            default: load_ext = bus.ram_rdata;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        bus.cpu_rdata = '0;
        bus.cpu_done  = 1'b0;
        bus.cpu_exc   = 1'b0;
        bus.ext_rdata = '0;
        bus.ext_done  = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;

        // A read pending at reset is dropped: no done in the reset cycle.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (ext_win) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.ext_addr[ADDR_W+1:2];
                        if (bus.ext_we) begin
                            bus.ram_we    = 4'b1111;
                            bus.ram_wdata = bus.ext_wdata;
                            bus.ext_done  = 1'b1;
                        end else begin
                            state_nxt = EXT_RD;
                        end
                    end else if (cpu_win) begin
                        if (misaligned) begin
                            bus.cpu_exc  = 1'b1;
                            bus.cpu_done = 1'b1;
                        end else begin
                            bus.ram_en   = 1'b1;
                            bus.ram_addr = bus.cpu_addr[ADDR_W+1:2];
                            if (bus.cpu_we) begin
                                bus.ram_we    = store_be;
                                bus.ram_wdata = store_data;
                                bus.cpu_done  = 1'b1;
                            end else begin
                                state_nxt = CPU_RD;
                            end
                        end
                    end
                end
                CPU_RD: begin
                    bus.cpu_done  = 1'b1;
                    bus.cpu_rdata = load_ext;
                    state_nxt     = IDLE;
                end
                EXT_RD: begin
                    bus.ext_done  = 1'b1;
                    bus.ext_rdata = bus.ram_rdata;
                    state_nxt     = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            // The EXT_RD cycle is ext being served, so it does not count as waiting.
            if (!bus.ext_req || ext_win || state == EXT_RD) begin
                wait_cnt <= '0;
            end else if (wait_cnt != STARVE_C) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // NOTE: load attributes are pure datapath, only meaningful after a grant, so no reset.
    always_ff @(posedge clk) begin
        if (cpu_win && !bus.cpu_we) begin
            rd_off   <= bus.cpu_addr[1:0];
            rd_width <= bus.cpu_width;
            rd_sign  <= bus.cpu_sign;
        end
    end
endmodule
